// File: rtl/down_cnt_ctrl.sv
// down_cnt_ctrl: button-driven set/run/pause/alarm front-end for a BCD MM:SS down counter
module down_cnt_ctrl #(
  parameter int ALARM_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       start_pulse,
  input  logic [3:0] cur0,
  input  logic [3:0] cur1,
  input  logic [3:0] cur2,
  input  logic [3:0] cur3,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [1:0] set,
  output logic       switch,
  output logic       alarm
);
  localparam int TW = $clog2(ALARM_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SET_MIN, SET_SEC, RUN, PAUSE, EXPIRED} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic zero, st, md, in, load_cur, inc_min, inc_sec;
  logic mu_wrap, su_wrap;
  logic [3:0] mu_nx, mt_nx, su_nx, sd_nx;
  assign zero = (cur3 | cur2 | cur1 | cur0) == 4'd0;
  assign st = start_pulse;
  assign md = mode_pulse & ~start_pulse;
  assign in = inc_pulse & ~mode_pulse & ~start_pulse;
  assign mu_wrap = val2 >= 4'd9;
  assign mu_nx = mu_wrap ? 4'd0 : val2 + 4'd1;
  assign mt_nx = mu_wrap ? (val3 >= 4'd9 ? 4'd0 : val3 + 4'd1) : val3;
  assign su_wrap = val0 >= 4'd9;
  assign su_nx = su_wrap ? 4'd0 : val0 + 4'd1;
  assign sd_nx = (val1 > 4'd5 || (su_wrap && val1 == 4'd5)) ? 4'd0 : val1 + {3'd0, su_wrap};
  assign set = state == SET_MIN ? 2'b01 : state == SET_SEC ? 2'b10 : 2'b00;
  assign switch = state == RUN;
  assign alarm = state == EXPIRED;
  // next-state, alarm timer and edit strobes; start beats mode beats inc
  always_comb begin
    state_nx = state;
    tmr_nx = '0;
    load_cur = 1'b0;
    inc_min = 1'b0;
    inc_sec = 1'b0;
    case (state)
      IDLE, PAUSE: begin
        if (st) state_nx = zero ? state : RUN;
        else if (md) begin
          state_nx = SET_MIN;
          load_cur = 1'b1;
        end
      end
      SET_MIN: begin
        if (st) state_nx = IDLE;
        else if (md) state_nx = SET_SEC;
        else inc_min = in;
      end
      SET_SEC: begin
        if (st || md) state_nx = IDLE;
        else inc_sec = in;
      end
      RUN: state_nx = zero ? EXPIRED : st ? PAUSE : RUN;
      EXPIRED: begin
        if (st || md || tmr == TW'(ALARM_CYCLES - 1)) state_nx = IDLE;
        else tmr_nx = tmr + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and alarm timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
    end else begin
      state <= state_nx;
      tmr <= tmr_nx;
    end
  end
  // preload digits: snapshot the live time on entering edit, BCD-increment the edited field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {val3, val2, val1, val0} <= '0;
    else if (load_cur) {val3, val2, val1, val0} <= {cur3, cur2, cur1, cur0};
    else if (inc_min) {val3, val2} <= {mt_nx, mu_nx};
    else if (inc_sec) {val1, val0} <= {sd_nx, su_nx};
  end
endmodule

// File: tb/tb_down_cnt_ctrl.sv
// tb_down_cnt_ctrl: table-driven and directed checks of down_cnt_ctrl against a down-counter model
module tb_down_cnt_ctrl;
  logic clk = 0, rst_n = 0, mode_pulse = 0, inc_pulse = 0, start_pulse = 0;
  logic [3:0] cur0, cur1, cur2, cur3, val0, val1, val2, val3;
  logic [1:0] set;
  logic switch, alarm;
  logic pre_en = 0;
  logic [15:0] pre_v = 0, cnt;
  int n_vec = 0, n_err = 0;
  typedef struct {logic s; logic m; logic i; int rep; logic [1:0] set; logic sw; logic [15:0] val;} vec_t;
  vec_t tbl[25];

  down_cnt_ctrl #(.ALARM_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode_pulse(mode_pulse), .inc_pulse(inc_pulse), .start_pulse(start_pulse),
    .cur0(cur0), .cur1(cur1), .cur2(cur2), .cur3(cur3),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .set(set), .switch(switch), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dec(input logic [15:0] c);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = c;
    if (s0 != 0) s0 = s0 - 1;
    else begin
      s0 = 9;
      if (s1 != 0) s1 = s1 - 1;
      else begin
        s1 = 5;
        if (m0 != 0) m0 = m0 - 1;
        else begin
          m0 = 9;
          m1 = m1 - 1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // model of the external down counter: loads val while set!=0, decrements while switch
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (pre_en) cnt <= pre_v;
    else if (set != 2'b00) cnt <= {val3, val2, val1, val0};
    else if (switch && cnt != 0) cnt <= dec(cnt);
  end
  assign {cur3, cur2, cur1, cur0} = cnt;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    start_pulse = 0;
    mode_pulse = 0;
    inc_pulse = 0;
    pre_en = 0;
  endtask

  task automatic chk(input string nm, input logic [1:0] es, input logic esw, input logic eal, input logic [15:0] ev);
    n_vec++;
    if ({set, switch, alarm, val3, val2, val1, val0} !== {es, esw, eal, ev}) begin
      n_err++;
      $display("FAIL %s: got set=%b sw=%b alarm=%b val=%h, want set=%b sw=%b alarm=%b val=%h",
               nm, set, switch, alarm, {val3, val2, val1, val0}, es, esw, eal, ev);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic preset(input logic [15:0] v);
    pre_v = v;
    pre_en = 1;
    step();
  endtask

  task automatic wait_alarm(input string nm, output int cyc);
    cyc = 0;
    while (!alarm && cyc < 20) begin
      step();
      cyc++;
    end
    chk_int(nm, int'(alarm), 1);
  endtask

  initial begin
    int runs, al, cyc;
    tbl[0]  = '{1, 0, 0, 1,  2'd0, 0, 16'h0000};
    tbl[1]  = '{0, 1, 0, 1,  2'd1, 0, 16'h0000};
    tbl[2]  = '{0, 0, 1, 12, 2'd1, 0, 16'h1200};
    tbl[3]  = '{0, 0, 1, 88, 2'd1, 0, 16'h0000};
    tbl[4]  = '{0, 0, 1, 1,  2'd1, 0, 16'h0100};
    tbl[5]  = '{0, 1, 1, 1,  2'd2, 0, 16'h0100};
    tbl[6]  = '{0, 0, 1, 58, 2'd2, 0, 16'h0158};
    tbl[7]  = '{0, 0, 1, 1,  2'd2, 0, 16'h0159};
    tbl[8]  = '{0, 0, 1, 1,  2'd2, 0, 16'h0100};
    tbl[9]  = '{0, 1, 0, 1,  2'd0, 0, 16'h0100};
    tbl[10] = '{0, 1, 0, 1,  2'd1, 0, 16'h0100};
    tbl[11] = '{0, 1, 0, 1,  2'd2, 0, 16'h0100};
    tbl[12] = '{0, 0, 1, 20, 2'd2, 0, 16'h0120};
    tbl[13] = '{1, 0, 0, 1,  2'd0, 0, 16'h0120};
    tbl[14] = '{1, 0, 0, 1,  2'd0, 1, 16'h0120};
    tbl[15] = '{0, 1, 1, 1,  2'd0, 1, 16'h0120};
    tbl[16] = '{1, 0, 0, 1,  2'd0, 0, 16'h0120};
    tbl[17] = '{0, 0, 1, 3,  2'd0, 0, 16'h0120};
    tbl[18] = '{0, 1, 0, 1,  2'd1, 0, 16'h0118};
    tbl[19] = '{1, 0, 0, 1,  2'd0, 0, 16'h0118};
    tbl[20] = '{0, 1, 0, 1,  2'd1, 0, 16'h0118};
    tbl[21] = '{0, 0, 1, 99, 2'd1, 0, 16'h0018};
    tbl[22] = '{0, 1, 0, 1,  2'd2, 0, 16'h0018};
    tbl[23] = '{0, 0, 1, 45, 2'd2, 0, 16'h0003};
    tbl[24] = '{0, 1, 0, 1,  2'd0, 0, 16'h0003};
    repeat (2) @(negedge clk);
    chk("in_reset", 2'd0, 0, 0, 16'h0000);
    rst_n = 1;
    step();
    chk("after_reset", 2'd0, 0, 0, 16'h0000);
    for (int k = 0; k < 25; k++) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        start_pulse = tbl[k].s;
        mode_pulse = tbl[k].m;
        inc_pulse = tbl[k].i;
        step();
      end
      chk($sformatf("vec%0d", k), tbl[k].set, tbl[k].sw, 1'b0, tbl[k].val);
    end
    start_pulse = 1;
    step();
    chk("run_from_0003", 2'd0, 1, 0, 16'h0003);
    runs = 1;
    for (int c = 0; c < 20 && !alarm; c++) begin
      step();
      if (switch) runs++;
    end
    chk_int("run_cycles", runs, 4);
    chk("expired", 2'd0, 0, 1, 16'h0003);
    al = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!alarm) break;
      al++;
    end
    chk_int("alarm_len", al, 16);
    chk("auto_idle", 2'd0, 0, 0, 16'h0003);
    preset(16'h0002);
    start_pulse = 1;
    step();
    wait_alarm("reach_alarm", cyc);
    repeat (3) step();
    chk("alarm_cycle3", 2'd0, 0, 1, 16'h0003);
    mode_pulse = 1;
    step();
    chk("mode_aborts_alarm", 2'd0, 0, 0, 16'h0003);
    preset(16'h0002);
    start_pulse = 1;
    step();
    chk("run2", 2'd0, 1, 0, 16'h0003);
    step();
    step();
    chk("run_at_zero", 2'd0, 1, 0, 16'h0003);
    start_pulse = 1;
    step();
    chk("zero_beats_start", 2'd0, 0, 1, 16'h0003);
    start_pulse = 1;
    step();
    chk("start_aborts_alarm", 2'd0, 0, 0, 16'h0003);
    preset(16'h0530);
    start_pulse = 1;
    step();
    step();
    chk("run_0530", 2'd0, 1, 0, 16'h0003);
    #2 rst_n = 0;
    #1 chk("async_reset", 2'd0, 0, 0, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("idle_after_reset", 2'd0, 0, 0, 16'h0000);
    preset(16'h0530);
    start_pulse = 1;
    step();
    chk("start_after_reset", 2'd0, 1, 0, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
